// File: rtl/dtm_dmi_master.sv
// DMI initiator: turns one synchronised TAP dmi command into a single DM request,
// collects read data, and keeps the sticky dmistat code reported back to the TAP.
module dtm_dmi_master #(
    parameter int OP_WIDTH   = 2,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                                     sys_clk,
    input  logic                                     sys_rst,
    input  logic                                     dmi_start,
    input  logic [OP_WIDTH-1:0]                      dmi_op,
    input  logic [ADDR_WIDTH-1:0]                    dmi_addr,
    input  logic [DATA_WIDTH-1:0]                    dmi_wdata,
    input  logic                                     dmireset,
    input  logic                                     dmihardreset,
    output logic                                     dmi_busy,
    output logic                                     dmi_done,
    output logic [DATA_WIDTH-1:0]                    dmi_rdata,
    output logic [1:0]                               dmi_stat,
    output logic                                     dtm_req_valid,
    input  logic                                     dtm_req_ready,
    output logic [OP_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] dtm_req_bits,
    input  logic                                     dm_resp_valid,
    output logic                                     dm_resp_ready,
    input  logic [OP_WIDTH+DATA_WIDTH-1:0]           dm_resp_bits
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int REQ_W  = OP_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int RESP_W = OP_WIDTH + DATA_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_READ  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_WRITE = OP_WIDTH'(2);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              stat_q, stat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    resp_ready_q, resp_ready_d;
    logic [1:0]              err_code;
    logic [1:0]              stat_base;

    // The response op field carries nothing this side needs.
    logic unused_resp_op;
    assign unused_resp_op = ^dm_resp_bits[RESP_W-1:DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_code     = STAT_OK;

        case (state_q)
            IDLE: begin
                if (dmi_start) begin
                    if (dmi_op == OP_READ || dmi_op == OP_WRITE) begin
                        op_d    = dmi_op;
                        addr_d  = dmi_addr;
                        wdata_d = dmi_wdata;
                        cnt_d   = '0;
                        state_d = REQ;
                    end else if (dmi_op == OP_NOP) begin
                        done_d = 1'b1;
                    end else begin
                        done_d   = 1'b1;
                        err_code = STAT_FAILED;
                    end
                end
            end
            REQ: begin
                if (dtm_req_ready) begin
                    if (op_q == OP_READ) begin
                        state_d = RESP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                if (dm_resp_valid) begin
                    rdata_d = dm_resp_bits[DATA_WIDTH-1:0];
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A real completion on the final counted cycle wins over the abort.
        if (state_q != IDLE) begin
            if (dmi_start) begin
                err_code = STAT_BUSY;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST && state_d != IDLE) begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (err_code < STAT_FAILED) begin
                    err_code = STAT_FAILED;
                end
            end
        end

        // A fresh error beats a simultaneous dmireset; codes only ever rise.
        stat_base = dmireset ? STAT_OK : stat_q;
        stat_d    = (err_code > stat_base) ? err_code : stat_base;

        busy_d       = (state_d != IDLE);
        resp_ready_d = (state_d != REQ);

        if (dmihardreset) begin
            state_d      = IDLE;
            cnt_d        = '0;
            op_d         = '0;
            addr_d       = '0;
            wdata_d      = '0;
            rdata_d      = rdata_q;
            done_d       = 1'b0;
            stat_d       = STAT_OK;
            busy_d       = 1'b0;
            resp_ready_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            stat_q       <= STAT_OK;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            stat_q       <= stat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            resp_ready_q <= resp_ready_d;
        end
    end

    // The DM samples any valid, so valid only ever mirrors ready while in REQ.
    assign dtm_req_valid = (state_q == REQ) && dtm_req_ready;
    assign dtm_req_bits  = (state_q == REQ) ? {wdata_q, addr_q, op_q} : REQ_W'(0);
    assign dm_resp_ready = resp_ready_q;
    assign dmi_busy      = busy_q;
    assign dmi_done      = done_q;
    assign dmi_rdata     = rdata_q;
    assign dmi_stat      = stat_q;

endmodule

// File: doc/dtm_dmi_master.md
Name: dtm_dmi_master

Overview:
- DMI initiator on the transport side of the debug bus. It drives the debug module's register request port and collects its read responses.
- Takes one access command at a time from the JTAG TAP's dmi shift register, already synchronised into sys_clk.
- Presents the request to the DM for exactly one accepted cycle and waits for read data where needed.
- Reports completion, read data and a sticky dmistat status back to the TAP, for capture into dtmcs/dmi.

Parameters:
- OP_WIDTH, 2, DMI op field width.
- ADDR_WIDTH, 7, DMI address width.
- DATA_WIDTH, 32, DMI data width.
- TIMEOUT, 1023, max cycles spent in REQ+RESP before abort; counter width is clog2(TIMEOUT+1).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- dmi_start  in  1  one-cycle pulse: launch access.
- dmi_op  in  OP_WIDTH  0 nop, 1 read, 2 write, 3 reserved.
- dmi_addr  in  ADDR_WIDTH  DM register address.
- dmi_wdata  in  DATA_WIDTH  write data.
- dmireset  in  1  pulse: clear sticky dmi_stat.
- dmihardreset  in  1  pulse: abort any access, clear state.
- dmi_busy  out  1  access in progress.
- dmi_done  out  1  one-cycle completion pulse.
- dmi_rdata  out  DATA_WIDTH  last read data.
- dmi_stat  out  2  sticky: 0 ok, 2 failed, 3 busy.
- dtm_req_valid  out  1  request strobe to DM.
- dtm_req_ready  in  1  DM able to accept.
- dtm_req_bits  out  OP_WIDTH+ADDR_WIDTH+DATA_WIDTH  {data, addr, op}, op in LSBs.
- dm_resp_valid  in  1  DM response valid.
- dm_resp_ready  out  1  response accept.
- dm_resp_bits  in  OP_WIDTH+DATA_WIDTH  {op, data}, data in LSBs.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, latched op/addr/wdata 0.
- States: IDLE, REQ, RESP.
- IDLE, dmi_start:
  - op=1 or 2: latch op/addr/wdata, go to REQ, clear counter, dmi_busy=1 from the next cycle.
  - op=0: no DM transaction; dmi_done the next cycle; stat unchanged.
  - op=3: no transaction; dmi_stat<=2; dmi_done the next cycle.
- REQ:
  - dtm_req_valid = dtm_req_ready (combinational gate). The DM samples any valid request, so valid is never high while ready is low, and is high for exactly one cycle per access.
  - dtm_req_bits are driven from the latched fields throughout REQ, and are 0 in other states.
  - On the accept cycle: a write goes to IDLE with dmi_done=1 the next cycle. A read goes to RESP.
- RESP:
  - dm_resp_ready=1.
  - On dm_resp_valid: dmi_rdata<=dm_resp_bits[DATA_WIDTH-1:0]; go to IDLE; dmi_done the next cycle.
- dm_resp_ready is also 1 in IDLE, so stray responses are drained and ignored (rdata unchanged). It is 0 in REQ.
- Latency with ready=1, start at cycle 0:
  - Write: valid at cycle 1, done at cycle 2.
  - Read: DM responds at cycle 2, done and rdata valid at cycle 3.
- Timeout: the counter increments each cycle in REQ or RESP. When it reaches TIMEOUT: stat<=2, done pulse, IDLE, valid low, rdata unchanged.
- dmi_start while busy: ignored; dmi_stat<=3 (sticky); the current access is unaffected.
- dmi_stat is sticky. Nonzero is only cleared by dmireset or dmihardreset. A higher code overwrites a lower one (3 over 2, 2 over 0); a lower code never overwrites a higher one.
- dmireset in the same cycle as a new error: the error wins.
- dmihardreset: next cycle state=IDLE, valid=0, stat=0, counter=0, no done pulse. rdata is retained. It overrides dmi_start in the same cycle.
- Asynchronous sys_rst mid-access: everything returns to reset values immediately; no done pulse.
- dmi_done and dmi_busy are registered. dmi_busy falls in the same cycle dmi_done rises.

Test Plan:
- Write: start op=2 addr=0x10 wdata=0x80000000, ready=1 -> dtm_req_bits={0x80000000,0x10,2'b10} valid exactly 1 cycle; done at cycle 2; stat=0.
- Read with backpressure: ready=0 for 5 cycles then 1, op=1 addr=0x04 -> valid low while ready low, high 1 cycle; DM responds data 0xDEADBEEF -> dmi_rdata=0xDEADBEEF, done 1 cycle after the response.
- Timeout: TIMEOUT=15, read, no dm_resp_valid -> done and stat=2 at 15 cycles after entering REQ; a later stray response is ignored and rdata unchanged.
- Busy overlap: second start during RESP -> stat=3, first access completes normally; dmireset -> stat=0.
- nop/reserved: op=0 -> done, no valid, stat unchanged; op=3 -> done, no valid, stat=2.
- dmihardreset during REQ with ready=0 -> IDLE next cycle, valid never asserts, no done, stat=0; sys_rst mid-read -> all outputs 0.
